// File: rtl/link_arbiter.sv
// Round-robin burst arbiter merging NUM_SRC valid/ready streams onto one registered link.
// Each grant carries up to MAX_BURST beats, and one idle cycle separates consecutive grants.
module link_arbiter #(
    parameter int WIDTH     = 64,
    parameter int NUM_SRC   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*WIDTH-1:0]    src_data,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_SRC)-1:0]  out_src,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last;
    logic [7:0]         beat_cnt;

    logic               hit;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    int                 idx;
    logic               can_take;
    logic               accept;

    // Search for the next valid source, starting just after the previous owner.
    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        cand = '0;
        idx  = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            cand = IDX_W'(idx);
            if (!hit && src_valid[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    assign can_take = (state == GRANT) && (!out_valid || out_ready);
    assign accept   = can_take && src_valid[grant];
    assign busy     = (state == GRANT) || out_valid;

    always_comb begin
        src_ready = '0;
        if (can_take) begin
            src_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IDX_W'(NUM_SRC - 1);
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            // A new beat takes priority over draining, so out_valid stays high back-to-back.
            if (accept) begin
                out_data  <= src_data[int'(grant)*WIDTH +: WIDTH];
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hit) begin
                        state    <= GRANT;
                        grant    <= sel;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt + 8'd1 == 8'(MAX_BURST)) begin
                            state <= IDLE;
                            last  <= grant;
                        end
                    end else if (can_take) begin
                        // Offered a slot but the owner had nothing: release the link.
                        state <= IDLE;
                        last  <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: vector table, directed corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_link_arbiter;

    localparam int WIDTH     = 64;
    localparam int NUM_SRC   = 3;
    localparam int MAX_BURST = 4;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_SRC*WIDTH-1:0]   src_data;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC-1:0]         src_ready;
    logic [WIDTH-1:0]           out_data;
    logic [1:0]                 out_src;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;

    link_arbiter #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sv;
        logic       orr;
        logic [2:0] rdy;
        logic       ov;
        logic [1:0] osrc;
        logic       bsy;
    } vec_t;

    vec_t tbl [13];
    vec_t none_row;

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (-1 when idle), previous owner, beats taken this grant,
    // and the single-entry output holding register.
    int          owner;
    int          prev;
    int          taken;
    bit          hv;
    logic [63:0] hdata;
    int          hsrc;

    bit record = 1'b0;
    int src_log [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        owner = -1;
        prev  = NUM_SRC - 1;
        taken = 0;
        hv    = 1'b0;
        hdata = '0;
        hsrc  = 0;
    endfunction

    function automatic logic [NUM_SRC-1:0] model_ready();
        logic [NUM_SRC-1:0] r;
        r = '0;
        if (owner >= 0 && (!hv || out_ready)) r[owner] = 1'b1;
        return r;
    endfunction

    function automatic void model_edge();
        logic [NUM_SRC-1:0] r;
        bit acc;
        r   = model_ready();
        acc = (owner >= 0) && r[owner] && src_valid[owner];
        if (hv && out_ready) hv = 1'b0;
        if (acc) begin
            hv    = 1'b1;
            hdata = src_data[owner*WIDTH +: WIDTH];
            hsrc  = owner;
        end
        if (owner < 0) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (owner < 0 && src_valid[(prev + k) % NUM_SRC]) begin
                    owner = (prev + k) % NUM_SRC;
                    taken = 0;
                end
            end
        end else if (r[owner]) begin
            if (acc) begin
                taken++;
                if (taken == MAX_BURST) begin
                    prev  = owner;
                    owner = -1;
                end
            end else begin
                prev  = owner;
                owner = -1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [2:0] sv, input logic orr);
        src_valid = sv;
        out_ready = orr;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i*WIDTH +: WIDTH] = {$urandom(), $urandom()};
        end
    endtask

    task automatic step(input bit has_row, input vec_t row);
        @(negedge clk);
        if (has_row) begin
            checkOutput("tbl_src_ready", src_ready, row.rdy);
            checkOutput("tbl_out_valid", out_valid, row.ov);
            checkOutput("tbl_out_src", out_src, row.osrc);
            checkOutput("tbl_busy", busy, row.bsy);
        end
        checkOutput("src_ready", src_ready, model_ready());
        checkOutput("out_valid", out_valid, hv);
        checkOutput("busy", busy, (owner >= 0) || hv);
        checkOutput("out_data", out_data, hdata);
        checkOutput("out_src", out_src, hsrc);
        if (record && out_valid) src_log.push_back(int'(out_src));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        src_valid = '0;
        out_ready = 1'b0;
        src_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [63:0] saved;

    initial begin
        none_row = '{default: '0};
        tbl[0]  = '{3'b100, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{3'b100, 1'b1, 3'b100, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{3'b001, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[3]  = '{3'b001, 1'b1, 3'b000, 1'b0, 2'd2, 1'b0};
        tbl[4]  = '{3'b001, 1'b0, 3'b001, 1'b0, 2'd2, 1'b1};
        tbl[5]  = '{3'b001, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
        tbl[6]  = '{3'b000, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
        tbl[7]  = '{3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
        tbl[8]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{3'b010, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{3'b010, 1'b1, 3'b010, 1'b0, 2'd0, 1'b1};
        tbl[11] = '{3'b000, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
        tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 1'b0};

        apply_reset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].sv, tbl[i].orr);
            step(1'b1, tbl[i]);
        end

        // All sources contending: grants rotate 0,1,2,0 with full bursts.
        apply_reset();
        src_log.delete();
        record = 1'b1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus(3'b111, 1'b1);
            step(1'b0, none_row);
        end
        record = 1'b0;
        checkOutput("rr_log_len", (src_log.size() >= 12), 1'b1);
        if (src_log.size() >= 12) begin
            for (int k = 0; k < 12; k++) checkOutput("rr_order", src_log[k], k / 4);
        end

        // Downstream stall after two beats of source 0.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, 1'b1);
            step(1'b0, none_row);
        end
        saved = hdata;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b001, 1'b0);
            step(1'b0, none_row);
            checkOutput("stall_data", out_data, saved);
            checkOutput("stall_ready", src_ready, 3'b000);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b001, 1'b1);
            step(1'b0, none_row);
        end

        // Asynchronous reset in the middle of a burst.
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, 1'b1);
            step(1'b0, none_row);
        end
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_src_ready", src_ready, 3'b000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_out_data", out_data, 64'd0);
        model_reset();
        applyStimulus(3'b110, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, none_row);
        checkOutput("post_rst_grant", src_ready, 3'b010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b110, 1'b1);
            step(1'b0, none_row);
        end

        // Randomized traffic against the reference model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] sv;
            for (int b = 0; b < NUM_SRC; b++) sv[b] = ($urandom_range(0, 9) < 6);
            applyStimulus(sv, ($urandom_range(0, 3) != 0));
            step(1'b0, none_row);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
